// File: rtl/register_file.sv
// 32 x N register file: x00 hardwired to zero, two combinational read ports,
// optional write-to-read forwarding, asynchronous active-low clear.

// 32:1 N-bit select tree, one instance per read port.
module register_file_sel32 #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] data_i [32],
    input  logic [4:0]   sel_i,
    output logic [N-1:0] data_o
);

    logic [N-1:0] lvl1 [16];
    logic [N-1:0] lvl2 [8];
    logic [N-1:0] lvl3 [4];
    logic [N-1:0] lvl4 [2];

    // Binary tree of 2:1 muxes, LSB of the select resolves first.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            lvl1[i] = sel_i[0] ? data_i[2*i+1] : data_i[2*i];
        end
        for (int unsigned i = 0; i < 8; i++) begin
            lvl2[i] = sel_i[1] ? lvl1[2*i+1] : lvl1[2*i];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            lvl3[i] = sel_i[2] ? lvl2[2*i+1] : lvl2[2*i];
        end
        for (int unsigned i = 0; i < 2; i++) begin
            lvl4[i] = sel_i[3] ? lvl3[2*i+1] : lvl3[2*i];
        end
        data_o = sel_i[4] ? lvl4[1] : lvl4[0];
    end

endmodule

module register_file #(
    parameter int unsigned N      = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic [NREG-1:1] wr_dec;
    logic [N-1:0]    regs_q [NREG-1:1];
    logic [N-1:0]    regs_d [NREG-1:1];
    logic [N-1:0]    rd_vec [NREG];
    logic [N-1:0]    sel0;
    logic [N-1:0]    sel1;
    logic            byp0;
    logic            byp1;

    // One-hot write decoder; index 0 has no decoder bit, so writes to it vanish.
    always_comb begin
        for (int unsigned i = 1; i < NREG; i++) begin
            wr_dec[i] = (wr_addr == AW'(i));
        end
    end

    // Per-register load gated by its decoder bit and the write enable.
    always_comb begin
        for (int unsigned i = 1; i < NREG; i++) begin
            regs_d[i] = (wr_ena && wr_dec[i]) ? wr_data : regs_q[i];
        end
    end

    // Register storage, cleared immediately when rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read vector with x00 tied to zero.
    always_comb begin
        rd_vec[0] = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            rd_vec[i] = regs_q[i];
        end
    end

    register_file_sel32 #(.N(N)) u_sel0 (
        .data_i (rd_vec),
        .sel_i  (rd_addr0),
        .data_o (sel0)
    );

    register_file_sel32 #(.N(N)) u_sel1 (
        .data_i (rd_vec),
        .sel_i  (rd_addr1),
        .data_o (sel1)
    );

    // Forward an in-flight write to a matching read; never for x00 or in reset.
    always_comb begin
        byp0     = BYPASS && rst && wr_ena && (wr_addr != '0) && (wr_addr == rd_addr0);
        byp1     = BYPASS && rst && wr_ena && (wr_addr != '0) && (wr_addr == rd_addr1);
        rd_data0 = byp0 ? wr_data : sel0;
        rd_data1 = byp1 ? wr_data : sel1;
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one BYPASS=1 and one BYPASS=0 instance share stimulus
// and are checked against an array model every cycle plus literal pin checks.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_ena = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr0 = '0;
    logic [4:0]  rd_addr1 = '0;
    logic [31:0] b_rd0, b_rd1, n_rd0, n_rd1;

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl [32];

    always #5 clk = ~clk;

    register_file #(.N(32), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(b_rd0), .rd_addr1(rd_addr1), .rd_data1(b_rd1)
    );

    register_file #(.N(32), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(n_rd0), .rd_addr1(rd_addr1), .rd_data1(n_rd1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected read value from the architectural rules.
    function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit byp);
        if (rst !== 1'b1 || a == 5'd0) return 32'h0;
        if (byp && wr_ena && wr_addr == a) return wr_data;
        return mdl[a];
    endfunction

    // Reference storage: cleared by reset, written on the edge.
    initial for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (wr_ena && wr_addr != 5'd0) begin
            mdl[wr_addr] = wr_data;
        end
    end

    // Every-cycle comparison of all four read ports, away from the active edge.
    always @(negedge clk) begin
        chk("byp_rd0", b_rd0, expect_rd(rd_addr0, 1'b1));
        chk("byp_rd1", b_rd1, expect_rd(rd_addr1, 1'b1));
        chk("nob_rd0", n_rd0, expect_rd(rd_addr0, 1'b0));
        chk("nob_rd1", n_rd1, expect_rd(rd_addr1, 1'b0));
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        next_cycle();
        wr_ena  = 1'b0;
    endtask

    task automatic pin_all(input string name, input logic [31:0] e0, input logic [31:0] e1);
        #1;
        chk({name, "_b0"}, b_rd0, e0);
        chk({name, "_b1"}, b_rd1, e1);
        chk({name, "_n0"}, n_rd0, e0);
        chk({name, "_n1"}, n_rd1, e1);
    endtask

    initial begin
        // Reset then read every index on both ports.
        #12;
        chk("reset_rd0", b_rd0, 32'h0);
        rst = 1'b1;
        next_cycle();
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(31 - a);
            pin_all("reset_all", 32'h0, 32'h0);
        end

        // Basic write/read, neighbour stays zero.
        wr(5'd5, 32'hDEADBEEF);
        rd_addr0 = 5'd5;
        rd_addr1 = 5'd5;
        pin_all("x05", 32'hDEADBEEF, 32'hDEADBEEF);
        rd_addr0 = 5'd6;
        pin_all("x06", 32'h0, 32'hDEADBEEF);

        // Writes to x00 are discarded, even forwarded during the write cycle.
        wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_addr0 = 5'd0; rd_addr1 = 5'd0;
        pin_all("x00_wcyc", 32'h0, 32'h0);
        next_cycle();
        wr_ena = 1'b0;
        pin_all("x00_after", 32'h0, 32'h0);

        // Forwarding vs. pre-write value.
        wr(5'd7, 32'h11111111);
        wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h22222222;
        rd_addr0 = 5'd7; rd_addr1 = 5'd7;
        #1;
        chk("fwd_byp", b_rd0, 32'h22222222);
        chk("fwd_nob", n_rd0, 32'h11111111);
        next_cycle();
        wr_ena = 1'b0;
        pin_all("fwd_after", 32'h22222222, 32'h22222222);

        // Back-to-back writes: the last one wins.
        wr(5'd9, 32'h00000001);
        wr(5'd9, 32'h00000002);
        rd_addr0 = 5'd9; rd_addr1 = 5'd7;
        pin_all("b2b", 32'h00000002, 32'h22222222);

        // Asynchronous reset between edges, writes ignored while held.
        wr(5'd31, 32'hA5A5A5A5);
        wr(5'd1, 32'h5A5A5A5A);
        rd_addr0 = 5'd31; rd_addr1 = 5'd1;
        pin_all("pre_rst", 32'hA5A5A5A5, 32'h5A5A5A5A);
        rst = 1'b0;
        pin_all("async_rst", 32'h0, 32'h0);
        wr_ena = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFFFFFF;
        pin_all("rst_nobyp", 32'h0, 32'h0);
        next_cycle();
        pin_all("rst_hold", 32'h0, 32'h0);
        rst = 1'b1;
        wr_ena = 1'b0;
        pin_all("post_rst", 32'h0, 32'h0);

        // First edge after reset release takes the write.
        wr(5'd3, 32'h00000033);
        rd_addr0 = 5'd3;
        pin_all("first_wr", 32'h00000033, 32'h0);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 1000; c++) begin
            wr_ena   = ($urandom_range(0, 3) != 0);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                chk("rnd_rst", b_rd0, 32'h0);
                rst = 1'b1;
            end
            next_cycle();
        end
        wr_ena = 1'b0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
